instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Upstream neighbour of the control unit in the single-cycle CPU.
//  Holds the PC, reads the instruction ROM and splits the word into fields.
//  Opcode drives the control unit. PCen/PCsrc come back from it to pick the next PC.
//  A RUN/HALT state machine stops fetch when a halt opcode is fetched or the PC leaves the ROM.
// PARAMETERS
//  MEM_BYTES  128          ROM size in bytes; byte-addressed; multiple of 4
//  INIT_FILE  "instr.mem"  $readmemb image, one byte per line
//  HALT_OP    6'b111111    opcode that halts the core
// PORTS
//  CLK        in   1   clock; all state changes on the rising edge
//  Reset      in   1   asynchronous, active-high; PC=0, state=RUN, InstrCnt=0
//  PCen       in   1   from control unit: 0 = load PC with 0 (synchronous), 1 = load next PC
//  PCsrc      in   2   00 PC+4; 01 branch; 10 jump; 11 hold PC
//  InsMemRW   in   1   1 = ROM read enabled; 0 = Instruction forced to 0
//  PC         out  32  current PC
//  PC4        out  32  PC+4, mod 2^32
//  Instruction out 32  fetched word, big-endian: byte[PC] is bits 31:24
//  Opcode     out  6   Instruction[31:26]
//  rs,rt,rd   out  5   Instruction[25:21], [20:16], [15:11]
//  Imm16      out  16  Instruction[15:0]
//  JAddr      out  26  Instruction[25:0]
//  Halted     out  1   1 while the state is HALT
//  InstrCnt   out  32  count of retired instructions; feature-gated, see CONFIGURATION
// BEHAVIOUR
//  Reset values: PC=0, Halted=0, InstrCnt=0. Field outputs follow ROM[0] combinationally.
//  Fetch is combinational from PC, so an instruction takes 0 cycles to fetch. PC updates once per edge.
//  Next PC, in state RUN:
//   - PCen=0: PC becomes 0. This overrides PCsrc.
//   - 00: PC+4.
//   - 01: PC+4 + (sign-extended Imm16 << 2), 32-bit wrap.
//   - 10: {PC4[31:28], JAddr, 2'b00}.
//   - 11: PC unchanged.
//  Out of range: if PC+3 >= MEM_BYTES, Instruction = {HALT_OP, 26'b0}. There is no partial-word read.
//  PC[1:0] is not masked. A misaligned PC reads 4 consecutive bytes.
//  States:
//   - RUN -> HALT on an edge where Opcode==HALT_OP and InsMemRW=1. The PC is not updated on that edge.
//   - HALT is absorbing. PC, InstrCnt and outputs are frozen, and PCen/PCsrc are ignored.
//   - Only Reset leaves HALT. Assertion is asynchronous at any time, mid-branch included. After release the first fetch is address 0.
//  Retire: an edge in RUN where PC is loaded (any PCen/PCsrc except PCsrc=11 with PCen=1).
//   - The halt instruction itself is not counted.
//  InsMemRW=0:
//   - The forced opcode 0 is not a halt, and the PC still advances per PCen/PCsrc.
// CONFIGURATION
//  IFETCH_INSTR_CNT_EN
//   - Defined: InstrCnt is a 32-bit counter, +1 on each retire edge, wrapping at 2^32.
//   - Undefined: InstrCnt is tied to 32'h0 and no counter flops exist. The port list is the same either way.
// STRUCTURE
//  Shared cpu_defs include: PCSRC_SEQ/BRANCH/JUMP/HOLD encodings, HALT_OP, ST_RUN/ST_HALT.
//  The control unit uses the same PCsrc encodings.
//  Sub-module instr_rom (params MEM_BYTES, INIT_FILE):
//   - addr[31:0] in, rd_en in, word[31:0] out.
//   - Big-endian assembly and the out-of-range halt word are done here.
//  instr_fetch keeps the PC register, next-PC mux, FSM and counter.
// TESTING
//  1 Reset mid-run at PC=0x10, async pulse with no clock -> PC=0 immediately; Instruction=ROM[0..3]; InstrCnt=0.
//  2 ROM 0x00 = branch with Imm16=0xFFFF, PCsrc=01 -> next PC=0x00 (PC4 0x04 - 4). Loops; InstrCnt +1 per edge.
//  3 PC=0x0C, JAddr=0x0000010, PCsrc=10 -> PC=0x40. PCen=0 on the next edge -> PC=0.
//  4 Halt at 0x08 -> edge 3 sets Halted=1, PC stays 0x08, InstrCnt=2. Further edges and PCsrc changes -> no change.
//  5 MEM_BYTES=16, straight-line code -> at PC=0x10 Opcode=HALT_OP. Halted=1 after 5 edges; PC=0x10.
//  6 InsMemRW=0, PCsrc=00 -> Instruction=0, no halt, PC+4. Build without IFETCH_INSTR_CNT_EN -> InstrCnt is always 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
// Definitions shared by the fetch stage and the control unit of the
// single-cycle CPU: next-PC select encodings, the default halt opcode,
// the RUN/HALT state type and the branch target helper.
// No ports (package).
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

    // Next-PC select as driven by the control unit on PCsrc
    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    // Fetch state machine states
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Opcode that stops the core
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    // Branch target: sign-extended word offset added to PC+4, wrapping at 2^32
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm16);
        return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_rom.sv
// ----------------------------------------------------------------------------
// instr_rom
// Byte-addressed instruction ROM with a combinational 32-bit read.
// The word is assembled big-endian (byte[addr] lands in bits 31:24). Any
// read whose last byte falls outside the ROM returns a halt instruction
// instead of a partial word. Contents arrive as the ROM_IMAGE parameter,
// byte i held in ROM_IMAGE[8*i +: 8], so the array is a pure constant.
// Ports:
//   addr   in  32  byte address, not required to be word aligned
//   rd_en  in   1  1 = read enabled, 0 = word forced to zero
//   word   out 32  fetched instruction word
// ----------------------------------------------------------------------------
module instr_rom
    import instr_fetch_pkg::*;
#(
    parameter int                     MEM_BYTES = 128,
    parameter logic [5:0]             HALT_OP   = HALT_OPCODE,
    parameter logic [MEM_BYTES*8-1:0] ROM_IMAGE = '0
) (
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] word
);

    localparam int ADDR_W = $clog2(MEM_BYTES);

    // One extra bit so addresses near 2^32 do not wrap back into range
    logic [32:0] lastByte;
    assign lastByte = {1'b0, addr} + 33'd3;

    // Read mux: disabled -> zero, out of range -> halt word, else four bytes
    always_comb begin
        logic [ADDR_W-1:0] byteIdx;
        word    = '0;
        byteIdx = '0;
        if (rd_en) begin
            if (lastByte >= 33'(MEM_BYTES)) begin
                word = {HALT_OP, 26'b0};
            end else begin
                for (int i = 0; i < 4; i++) begin
                    byteIdx             = addr[ADDR_W-1:0] + ADDR_W'(i);
                    word[31-8*i -: 8]   = ROM_IMAGE[{byteIdx, 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the single-cycle CPU. Holds the PC, reads the instruction
// ROM combinationally, splits the word into fields for the control unit and
// selects the next PC from PCen/PCsrc. A RUN/HALT machine stops fetching
// when a halt opcode is read (or the PC leaves the ROM); only Reset exits.
//
// Build option: define IFETCH_INSTR_CNT_EN to get a 32-bit retired
// instruction counter on InstrCnt; without it InstrCnt is constant zero and
// no counter flops exist.
//
// Ports:
//   CLK          in   1   clock, rising edge
//   Reset        in   1   asynchronous, active-high
//   PCen         in   1   0 = PC loads 0, 1 = PC loads next PC
//   PCsrc        in   2   00 PC+4, 01 branch, 10 jump, 11 hold
//   InsMemRW     in   1   ROM read enable
//   PC           out 32   current PC
//   PC4          out 32   PC+4
//   Instruction  out 32   fetched word
//   Opcode       out  6   Instruction[31:26]
//   rs, rt, rd   out  5   Instruction[25:21], [20:16], [15:11]
//   Imm16        out 16   Instruction[15:0]
//   JAddr        out 26   Instruction[25:0]
//   Halted       out  1   state is HALT
//   InstrCnt     out 32   retired instruction count
// ----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                     MEM_BYTES = 128,
    parameter logic [5:0]             HALT_OP   = HALT_OPCODE,
    parameter logic [MEM_BYTES*8-1:0] ROM_IMAGE = '0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCen,
    input  logic [1:0]  PCsrc,
    input  logic        InsMemRW,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] Imm16,
    output logic [25:0] JAddr,
    output logic        Halted,
    output logic [31:0] InstrCnt
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    state_e      state_q;
    logic        haltNow;

    instr_rom #(
        .MEM_BYTES (MEM_BYTES),
        .HALT_OP   (HALT_OP),
        .ROM_IMAGE (ROM_IMAGE)
    ) u_rom (
        .addr  (pc_q),
        .rd_en (InsMemRW),
        .word  (Instruction)
    );

    assign PC     = pc_q;
    assign PC4    = pc_q + 32'd4;
    assign Opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign Imm16  = Instruction[15:0];
    assign JAddr  = Instruction[25:0];
    assign Halted = (state_q == ST_HALT);

    // A disabled ROM reads as opcode 0, which must never count as a halt
    assign haltNow = (state_q == ST_RUN) && InsMemRW && (Opcode == HALT_OP);

    // Next-PC mux; PCen low forces PC to zero regardless of PCsrc
    always_comb begin
        pc_d = pc_q;
        if (!PCen) begin
            pc_d = '0;
        end else begin
            case (pcsrc_e'(PCsrc))
                PCSRC_SEQ:    pc_d = PC4;
                PCSRC_BRANCH: pc_d = branch_target(PC4, Imm16);
                PCSRC_JUMP:   pc_d = {PC4[31:28], JAddr, 2'b00};
                PCSRC_HOLD:   pc_d = pc_q;
                default:      pc_d = pc_q;
            endcase
        end
    end

    // RUN/HALT machine with the PC register; the halting edge leaves the PC
    // on the halt instruction and HALT then freezes everything until Reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (haltNow) begin
                        state_q <= ST_HALT;
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef IFETCH_INSTR_CNT_EN
    logic [31:0] instrCnt_q;
    logic        retire;

    // An instruction retires whenever the PC is actually loaded in RUN;
    // a plain hold (PCen=1, PCsrc=11) and the halt edge do not count
    assign retire = (state_q == ST_RUN) && !haltNow &&
                    !(PCen && (pcsrc_e'(PCsrc) == PCSRC_HOLD));

    // Retired instruction counter, wraps naturally at 2^32
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            instrCnt_q <= '0;
        end else if (retire) begin
            instrCnt_q <= instrCnt_q + 32'd1;
        end
    end

    assign InstrCnt = instrCnt_q;
`else
    assign InstrCnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Scoreboard bench for instr_fetch: the driver updates a behavioural CPU
// fetch model and queues the expected post-edge state; a monitor pops and
// compares after every clock edge or reset assertion.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int MEM = 128;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [31:0] cnt;
        logic [31:0] instr;
    } exp_t;

    // Program words: a few hand-placed instructions, the rest filler with
    // small branch offsets and non-halt opcodes
    function automatic logic [31:0] progWord(input int k);
        logic [31:0] w;
        case (k)
            0:       w = 32'h1000FFFF;
            1:       w = 32'h21090001;
            2:       w = 32'hFC000000;
            3:       w = 32'h08000010;
            5:       w = 32'h08000020;
            24:      w = 32'hFC000000;
            default: begin
                w = (32'(k) * 32'h9E3779B9) ^ 32'h5A5A1234;
                w[15:0] = {{12{w[3]}}, w[3:0]};
                if (w[31:26] == 6'h3F) w[31] = 1'b0;
            end
        endcase
        return w;
    endfunction

    function automatic logic [7:0] progByte(input int a);
        logic [31:0] w;
        w = progWord(a / 4);
        return w[31 - 8*(a % 4) -: 8];
    endfunction

    function automatic logic [MEM*8-1:0] buildImage();
        logic [MEM*8-1:0] img;
        img = '0;
        for (int a = 0; a < MEM; a++) img[a*8 +: 8] = progByte(a);
        return img;
    endfunction

    localparam logic [MEM*8-1:0] IMAGE = buildImage();

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        PCen = 1'b1;
    logic [1:0]  PCsrc = 2'b00;
    logic        InsMemRW = 1'b1;
    logic [31:0] PC, PC4, Instruction, InstrCnt;
    logic [5:0]  Opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] Imm16;
    logic [25:0] JAddr;
    logic        Halted;

    instr_fetch #(
        .MEM_BYTES (MEM),
        .HALT_OP   (6'b111111),
        .ROM_IMAGE (IMAGE)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCen        (PCen),
        .PCsrc       (PCsrc),
        .InsMemRW    (InsMemRW),
        .PC          (PC),
        .PC4         (PC4),
        .Instruction (Instruction),
        .Opcode      (Opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .Imm16       (Imm16),
        .JAddr       (JAddr),
        .Halted      (Halted),
        .InstrCnt    (InstrCnt)
    );

    always #5 CLK = ~CLK;

    exp_t        expQ[$];
    int          checks = 0;
    int          fails = 0;
    bit          started = 0;
    bit          done = 0;

    logic [31:0] mPc = '0;
    bit          mHalted = 0;
    logic [31:0] mCnt = '0;

    // Reference fetch: disabled -> 0, any byte past the ROM -> halt word
    function automatic logic [31:0] refFetch(input logic [31:0] pc, input logic en);
        longint unsigned last;
        int a;
        if (!en) return 32'h0;
        last = {32'b0, pc} + 64'd3;
        if (last >= 64'(MEM)) return {6'h3F, 26'b0};
        a = int'(pc);
        return {progByte(a), progByte(a+1), progByte(a+2), progByte(a+3)};
    endfunction

    function automatic logic [31:0] expCnt(input logic [31:0] c);
`ifdef IFETCH_INSTR_CNT_EN
        return c;
`else
        return 32'h0 & c;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check("PC", PC, e.pc);
        check("PC4", PC4, e.pc + 32'd4);
        check("Instruction", Instruction, e.instr);
        check("Opcode", 32'(Opcode), 32'(e.instr[31:26]));
        check("rs", 32'(rs), 32'(e.instr[25:21]));
        check("rt", 32'(rt), 32'(e.instr[20:16]));
        check("rd", 32'(rd), 32'(e.instr[15:11]));
        check("Imm16", 32'(Imm16), 32'(e.instr[15:0]));
        check("JAddr", 32'(JAddr), 32'(e.instr[25:0]));
        check("Halted", 32'(Halted), 32'(e.halted));
        check("InstrCnt", InstrCnt, expCnt(e.cnt));
    endtask

    function automatic exp_t snapshot(input logic en);
        exp_t e;
        e.pc     = mPc;
        e.halted = mHalted;
        e.cnt    = mCnt;
        e.instr  = refFetch(mPc, en);
        return e;
    endfunction

    // Drive one clock edge worth of control and queue the expected outcome
    task automatic applyStimulus(input logic pcen, input logic [1:0] src, input logic mem);
        logic [31:0] ins;
        logic [31:0] pc4;
        @(negedge CLK);
        PCen     = pcen;
        PCsrc    = src;
        InsMemRW = mHalted ? 1'b1 : mem;
        if (!mHalted) begin
            ins = refFetch(mPc, InsMemRW);
            if (InsMemRW && ins[31:26] == 6'h3F) begin
                mHalted = 1;
            end else begin
                pc4 = mPc + 32'd4;
                if (!(pcen && src == 2'd3)) mCnt = mCnt + 32'd1;
                if (!pcen)             mPc = 32'h0;
                else if (src == 2'd0)  mPc = pc4;
                else if (src == 2'd1)  mPc = pc4 + 32'($signed(ins[15:0])) * 32'd4;
                else if (src == 2'd2)  mPc = {pc4[31:28], ins[25:0], 2'b00};
            end
        end
        expQ.push_back(snapshot(InsMemRW));
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic resetPulse();
        @(posedge CLK);
        #2;
        started  = 1;
        InsMemRW = 1'b1;
        mPc      = '0;
        mHalted  = 0;
        mCnt     = '0;
        expQ.push_back(snapshot(1'b1));
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    // Monitor: one expectation per clock edge or reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or posedge Reset);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end else if (started && !done) begin
                checks++;
                fails++;
                $display("[TB] FAIL scoreboard: edge at %0t with no expectation queued", $time);
            end
        end
    end

    initial begin
        int haltAge;
        int r;
        logic [1:0] src;
        haltAge = 0;

        resetPulse();
        // Branch to itself: PC+4 plus offset -4
        repeat (3) applyStimulus(1'b1, 2'b01, 1'b1);
        // Straight-line into the halt at 0x08, then frozen
        repeat (2) applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1);

        resetPulse();
        // Pass the halt with the ROM disabled, jump, then PCen=0
        repeat (2) applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b1);
        // Reach 0x10 by branching over the halt, then reset mid-run
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);

        resetPulse();
        // Jump to 0x80, the first address outside the ROM
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b1);

        resetPulse();
        for (int n = 0; n < 600; n++) begin
            if (mHalted) begin
                haltAge++;
                if (haltAge > 2) begin
                    resetPulse();
                    haltAge = 0;
                end
            end else if ($urandom_range(0, 99) < 2) begin
                resetPulse();
            end
            r = int'($urandom_range(0, 99));
            src = (r < 55) ? 2'd0 : (r < 85) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
            applyStimulus($urandom_range(0, 99) < 92, src, $urandom_range(0, 99) < 90);
        end

        @(posedge CLK);
        #2;
        done = 1;
        check("queue drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
